// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and job configuration for the matrix job sequencer.
package matrix_pkg;

    localparam int unsigned DIM_MAX    = 5;
    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned LANES      = DIM_MAX * DIM_MAX;
    localparam int unsigned LANE_BUS_W = LANES * ELEM_W;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned DIM_W      = 3;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_ADDR = 3'd1;
    localparam state_t ST_RD_DATA = 3'd2;
    localparam state_t ST_KICK    = 3'd3;
    localparam state_t ST_WAIT    = 3'd4;
    localparam state_t ST_WR      = 3'd5;
    localparam state_t ST_WR_OVF  = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] size;
        logic [7:0] scalar;
    } job_cfg_t;

    // matrix_size code 0..3 maps to a square dimension of 2..5
    function automatic logic [DIM_W-1:0] dim_of(input logic [1:0] size);
        return DIM_W'(size) + DIM_W'(2);
    endfunction

endpackage

// File: rtl/matrix_index_walker.sv
// Row-major (r,c) walker over an n x n window of a 5-wide lane grid; shared by read and write phases.
module matrix_index_walker
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [DIM_W-1:0] n,
    output logic [IDX_W-1:0] k,
    output logic             last
);

    logic [DIM_W-1:0] r;
    logic [DIM_W-1:0] c;
    logic [DIM_W-1:0] n_m1;

    assign n_m1 = n - DIM_W'(1);
    assign last = (r == n_m1) && (c == n_m1);
    assign k    = IDX_W'(IDX_W'(r) * IDX_W'(DIM_MAX)) + IDX_W'(c);

    // Wraps to the origin after the last element so the next phase starts clean
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r <= '0;
            c <= '0;
        end else if (step) begin
            if (last) begin
                r <= '0;
                c <= '0;
            end else if (c == n_m1) begin
                c <= '0;
                r <= r + DIM_W'(1);
            end else begin
                c <= c + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_job_sequencer.sv
// Runs one matrix job: gathers operands from memory, kicks the ALU, waits, then writes results and overflow back.
module matrix_job_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned MEM_AW      = 7,
    parameter int unsigned RESULT_BASE = 25,
    parameter int unsigned ALU_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op_code,
    input  logic [1:0]            matrix_size,
    input  logic [7:0]            scalar,
    output logic                  busy,
    output logic                  done,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [2:0]            alu_op,
    output logic [1:0]            alu_size,
    output logic [7:0]            alu_scalar,
    output logic [LANE_BUS_W-1:0] alu_a,
    output logic [LANE_BUS_W-1:0] alu_b,
    output logic                  alu_start,
    input  logic [LANE_BUS_W-1:0] alu_result,
    input  logic                  alu_overflow
);

    localparam int unsigned WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    state_t                  state;
    state_t                  state_nxt;
    job_cfg_t                cfg;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [LANE_BUS_W-1:0]   result_q;
    logic                    ovf_q;

    logic                    accept;
    logic                    capture;
    logic                    latch_res;
    logic                    walk_clear;
    logic                    walk_step;
    logic [IDX_W-1:0]        k;
    logic                    last;
    logic [7:0]              lane_bit;

    assign lane_bit = {k, 3'b000};

    matrix_index_walker u_walker (
        .clk   (clk),
        .reset (reset),
        .clear (walk_clear),
        .step  (walk_step),
        .n     (dim_of(cfg.size)),
        .k     (k),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        latch_res  = 1'b0;
        walk_clear = 1'b0;
        walk_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    walk_clear = 1'b1;
                    state_nxt  = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_nxt = ST_RD_DATA;
            ST_RD_DATA: begin
                capture   = 1'b1;
                walk_step = 1'b1;
                state_nxt = last ? ST_KICK : ST_RD_ADDR;
            end
            ST_KICK: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == WAIT_W'(ALU_LATENCY - 1)) begin
                    latch_res  = 1'b1;
                    walk_clear = 1'b1;
                    state_nxt  = ST_WR;
                end
            end
            ST_WR: begin
                walk_step = 1'b1;
                if (last) begin
                    state_nxt = ST_WR_OVF;
                end
            end
            ST_WR_OVF: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Job configuration, operand lanes, latency counter and captured ALU result
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wait_cnt <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                cfg   <= '{op: op_code, size: matrix_size, scalar: scalar};
                alu_a <= '0;
                alu_b <= '0;
            end
            if (capture) begin
                alu_a[lane_bit +: ELEM_W] <= mem_rdata[7:0];
                alu_b[lane_bit +: ELEM_W] <= mem_rdata[15:8];
            end
            if (state == ST_KICK) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (latch_res) begin
                result_q <= alu_result;
                ovf_q    <= alu_overflow;
            end
        end
    end

    // Memory port decodes from registered state and walker index only
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_RD_ADDR: mem_addr = MEM_AW'(k);
            ST_WR: begin
                mem_we    = 1'b1;
                mem_addr  = MEM_AW'(RESULT_BASE) + MEM_AW'(k);
                mem_wdata = {8'h00, result_q[lane_bit +: ELEM_W]};
            end
            ST_WR_OVF: begin
                mem_we    = 1'b1;
                mem_addr  = MEM_AW'(RESULT_BASE + LANES);
                mem_wdata = {15'b0, ovf_q};
            end
            default: ;
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign alu_start  = (state == ST_KICK);
    assign alu_op     = cfg.op;
    assign alu_size   = cfg.size;
    assign alu_scalar = cfg.scalar;

endmodule

// File: tb/tb_matrix_job_sequencer.sv
// Scoreboard bench for matrix_job_sequencer with a behavioural operand memory and an adding mock ALU.
module tb_matrix_job_sequencer;
    import matrix_pkg::*;

    localparam int unsigned MEM_AW      = 7;
    localparam int unsigned RESULT_BASE = 25;
    localparam int unsigned ALU_LATENCY = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op_code;
    logic [1:0]   matrix_size;
    logic [7:0]   scalar;
    logic         busy;
    logic         done;
    logic [6:0]   mem_addr;
    logic         mem_we;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic [2:0]   alu_op;
    logic [1:0]   alu_size;
    logic [7:0]   alu_scalar;
    logic [199:0] alu_a;
    logic [199:0] alu_b;
    logic         alu_start;
    logic [199:0] alu_result;
    logic         alu_overflow;
    logic         mock_ovf;

    typedef struct {
        int unsigned  cyc;
        logic [199:0] a;
        logic [199:0] b;
        logic [2:0]   op;
        logic [1:0]   size;
        logic [7:0]   scal;
    } kick_t;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    kick_t       kick_q[$];
    wr_t         wr_q[$];
    int unsigned done_q[$];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [24:0] rd_mask;
    logic [15:0] mem [0:127];

    matrix_job_sequencer #(
        .MEM_AW      (MEM_AW),
        .RESULT_BASE (RESULT_BASE),
        .ALU_LATENCY (ALU_LATENCY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_code      (op_code),
        .matrix_size  (matrix_size),
        .scalar       (scalar),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .alu_op       (alu_op),
        .alu_size     (alu_size),
        .alu_scalar   (alu_scalar),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memory: registered read, write-first not required
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Mock ALU: lane-wise 8-bit A+B
    always_comb begin
        alu_result = '0;
        for (int i = 0; i < 25; i++) begin
            alu_result[i*8 +: 8] = alu_a[i*8 +: 8] + alu_b[i*8 +: 8];
        end
    end
    assign alu_overflow = mock_ovf;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] lanes(input int n, input int base);
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                v[(r*5+c)*8 +: 8] = 8'(base + r*5 + c);
        return v;
    endfunction

    task automatic expect_job(input int unsigned acc, input int n, input logic [2:0] op,
                              input logic [1:0] sz, input logic [7:0] sc, input logic ovf);
        kick_t ke;
        wr_t   we;
        ke.cyc  = acc + 2*n*n + 1;
        ke.a    = lanes(n, 0);
        ke.b    = lanes(n, 100);
        ke.op   = op;
        ke.size = sz;
        ke.scal = sc;
        kick_q.push_back(ke);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                we.addr = 7'(25 + r*5 + c);
                we.data = {8'h00, 8'(100 + 2*(r*5 + c))};
                wr_q.push_back(we);
            end
        end
        we.addr = 7'd50;
        we.data = {15'b0, ovf};
        wr_q.push_back(we);
        done_q.push_back(acc + 3*n*n + ALU_LATENCY + 3);
    endtask

    // Drives start for one cycle at a negedge; acc is the cyc value before the accepting edge
    task automatic launch(input logic [1:0] sz, input logic [2:0] op, input logic [7:0] sc,
                          input logic ovf, input logic hold, output int unsigned acc);
        @(negedge clk);
        chk("idle_before_start", 200'(busy), 200'(0));
        op_code     = op;
        matrix_size = sz;
        scalar      = sc;
        start       = 1'b1;
        acc         = cyc;
        expect_job(acc, int'(sz) + 2, op, sz, sc, ovf);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, a kick or a done
    always @(negedge clk) begin
        wr_t         w;
        kick_t       kq;
        int unsigned dq;
        if (!reset) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 200'(mem_addr), 200'(w.addr));
                    chk("wr_data", 200'(mem_wdata), 200'(w.data));
                end
            end
            if (alu_start) begin
                if (kick_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL kick_unexpected: got alu_start at cyc %0d expected none", cyc);
                end else begin
                    kq = kick_q.pop_front();
                    chk("kick_cycle", 200'(cyc), 200'(kq.cyc));
                    chk("alu_a", alu_a, kq.a);
                    chk("alu_b", alu_b, kq.b);
                    chk("alu_cfg", 200'({alu_op, alu_size, alu_scalar}), 200'({kq.op, kq.size, kq.scal}));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done at cyc %0d expected none", cyc);
                end else begin
                    dq = done_q.pop_front();
                    chk("done_cycle", 200'(cyc), 200'(dq));
                end
            end
            if (busy && !mem_we && mem_addr < 7'd25) begin
                chk("rd_addr_allowed", 200'(rd_mask[mem_addr[4:0]]), 200'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int i;
        for (int a = 0; a < 128; a++) mem[a] = 16'hFFFF;
        for (int a = 0; a < 25; a++) mem[a] = {8'(100 + a), 8'(a)};
        reset       = 1'b1;
        start       = 1'b0;
        op_code     = '0;
        matrix_size = '0;
        scalar      = '0;
        mock_ovf    = 1'b0;
        rd_mask     = '1;

        repeat (3) @(negedge clk);
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_done", 200'(done), 200'(0));
        chk("rst_mem", 200'({mem_we, mem_addr, mem_wdata}), 200'(0));
        chk("rst_alu_start", 200'(alu_start), 200'(0));
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_alu_cfg", 200'({alu_op, alu_size, alu_scalar}), 200'(0));
        reset = 1'b0;

        // 5x5 full job, done expected 83 cycles after accept
        launch(2'b11, 3'd1, 8'h12, 1'b0, 1'b0, acc);
        wait_done(200);

        // 2x2 only touches lanes 0,1,5,6
        rd_mask = 25'b0000000000000000001100011;
        launch(2'b00, 3'd5, 8'hA5, 1'b0, 1'b0, acc);
        wait_done(100);
        rd_mask = '1;

        // 3x3 with overflow reported by the ALU
        mock_ovf = 1'b1;
        launch(2'b01, 3'd2, 8'h7F, 1'b1, 1'b0, acc);
        wait_done(100);
        chk("ovf_word", 200'(mem[50]), 200'(16'h0001));
        mock_ovf = 1'b0;

        // start held high: second 2x2 job accepted on the single IDLE cycle after DONE
        rd_mask = 25'b0000000000000000001100011;
        launch(2'b00, 3'd3, 8'h01, 1'b0, 1'b1, acc);
        expect_job(acc + 21, 2, 3'd3, 2'b00, 8'h01, 1'b0);
        wait_done(100);
        @(negedge clk);
        chk("held_idle_gap", 200'(busy), 200'(0));
        @(negedge clk);
        chk("held_rebusy", 200'(busy), 200'(1));
        start = 1'b0;
        wait_done(100);
        rd_mask = '1;

        // reset in the middle of the 5x5 write phase
        launch(2'b11, 3'd0, 8'h00, 1'b0, 1'b0, acc);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 7'd30) break;
        end
        if (i == 200) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: got no write to 30 expected one within 200 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", 200'(mem_we), 200'(0));
        chk("rst_mid_busy", 200'(busy), 200'(0));
        chk("rst_mid_done", 200'(done), 200'(0));
        chk("rst_mid_alu_a", alu_a, '0);
        wr_q.delete();
        done_q.delete();
        kick_q.delete();
        reset = 1'b0;

        // a 4x4 job after the abort completes normally
        launch(2'b10, 3'd4, 8'h33, 1'b0, 1'b0, acc);
        wait_done(150);
        repeat (3) @(negedge clk);

        chk("wr_q_drained", 200'(wr_q.size()), 200'(0));
        chk("kick_q_drained", 200'(kick_q.size()), 200'(0));
        chk("done_q_drained", 200'(done_q.size()), 200'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
